divmod_seq: RTL and testbench

Multi-cycle sequencer for signed and unsigned integer divide/remainder across the SystemVerilog integer widths (byte, shortint, int, longint). It accepts one operation at a time over a valid/ready handshake, sign- or zero-extends the operands for the selected kind, runs a one-bit-per-cycle restoring divider, and applies Verilog sign rules: the quotient truncates toward zero and the remainder takes the dividend's sign. It sits between issue logic and the shared arithmetic datapath, so one divider serves every integer width.

---
 rtl/divmod_pkg.sv | 53 +++++
 rtl/divmod_step.sv | 20 ++
 rtl/divmod_seq.sv | 154 +++++++++++++++
 tb/tb_divmod_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/divmod_pkg.sv
// Shared types and helpers for the sequential divide/remainder unit.
// Build option: DIVMOD_EARLY_OUT_EN skips the divide loop for zero operands.
package divmod_pkg;

    typedef enum logic [1:0] {
        KIND_BYTE,
        KIND_SHORTINT,
        KIND_INT,
        KIND_LONGINT
    } kind_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic [6:0] kind_width(kind_t kind);
        logic [6:0] w;
        unique case (kind)
            KIND_BYTE:     w = 7'd8;
            KIND_SHORTINT: w = 7'd16;
            KIND_INT:      w = 7'd32;
            default:       w = 7'd64;
        endcase
        return w;
    endfunction

    function automatic logic [63:0] ext(
        logic [63:0] value,
        kind_t       kind,
        logic        is_signed
    );
        logic [63:0] r;
        unique case (kind)
            KIND_BYTE:
                r = is_signed ? {{56{value[7]}}, value[7:0]}
                              : {56'd0, value[7:0]};
            KIND_SHORTINT:
                r = is_signed ? {{48{value[15]}}, value[15:0]}
                              : {48'd0, value[15:0]};
            KIND_INT:
                r = is_signed ? {{32{value[31]}}, value[31:0]}
                              : {32'd0, value[31:0]};
            default:
                r = value;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/divmod_step.sv
// One restoring division step: shift in the next dividend bit and
// trial-subtract the divisor.
module divmod_step (
    input  logic [63:0] rem,
    input  logic [63:0] divisor,
    input  logic        msb,
    output logic [63:0] rem_next,
    output logic        q_bit
);

    logic [64:0] shifted;
    logic [64:0] diff;

    assign shifted = {rem, msb};
    assign diff    = shifted - {1'b0, divisor};
    // rem < divisor always holds, so bit 64 of diff is exactly the borrow
    assign q_bit    = ~diff[64];
    assign rem_next = q_bit ? diff[63:0] : shifted[63:0];

endmodule

// File: rtl/divmod_seq.sv
// Multi-cycle signed/unsigned divide and remainder for 8/16/32/64-bit kinds.
// Build option: DIVMOD_EARLY_OUT_EN (zero operand jumps PREP -> FIX).
module divmod_seq
    import divmod_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic             req_signed,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_quo,
    output logic [63:0]      resp_rem,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_dz
);

    state_t           state;
    kind_t            kind_q;
    logic             sgn_q;
    logic [TAG_W-1:0] tag_q;
    logic [63:0]      a_q;
    logic [63:0]      b_q;
    logic [63:0]      abs_b;
    logic [63:0]      dvd;
    logic [63:0]      rem;
    logic [63:0]      quo;
    logic [6:0]       cnt;
    logic             neg_q;
    logic             neg_r;

    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] abs_a_c;
    logic [63:0] abs_b_c;
    logic [6:0]  width;
    logic [6:0]  align;
    logic [63:0] q_fix;
    logic [63:0] r_fix;
    logic [63:0] rem_next;
    logic        q_bit;
    logic        dz;

    always_comb begin
        ea      = ext(a_q, kind_q, sgn_q);
        eb      = ext(b_q, kind_q, sgn_q);
        abs_a_c = (sgn_q && ea[63]) ? -ea : ea;
        abs_b_c = (sgn_q && eb[63]) ? -eb : eb;
        width   = kind_width(kind_q);
        align   = 7'd64 - width;
        dz      = (eb == 64'd0);
        q_fix   = neg_q ? -quo : quo;
        r_fix   = neg_r ? -rem : rem;
    end

    divmod_step u_step (
        .rem      (rem),
        .divisor  (abs_b),
        .msb      (dvd[63]),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            kind_q     <= KIND_BYTE;
            sgn_q      <= 1'b0;
            tag_q      <= '0;
            a_q        <= 64'd0;
            b_q        <= 64'd0;
            abs_b      <= 64'd0;
            dvd        <= 64'd0;
            rem        <= 64'd0;
            quo        <= 64'd0;
            cnt        <= 7'd0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_quo   <= 64'd0;
            resp_rem   <= 64'd0;
            resp_tag   <= '0;
            resp_dz    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        kind_q    <= kind_t'(req_kind);
                        sgn_q     <= req_signed;
                        tag_q     <= req_tag;
                        a_q       <= req_a;
                        b_q       <= req_b;
                        req_ready <= 1'b0;
                        state     <= S_PREP;
                    end
                end
                S_PREP: begin
                    // left-align the dividend so its MSB is always bit 63
                    dvd   <= abs_a_c << align;
                    abs_b <= abs_b_c;
                    rem   <= 64'd0;
                    quo   <= 64'd0;
                    cnt   <= width;
                    neg_q <= sgn_q & (ea[63] ^ eb[63]);
                    neg_r <= sgn_q & ea[63];
                    state <= S_DIV;
`ifdef DIVMOD_EARLY_OUT_EN
                    if (ea == 64'd0 || eb == 64'd0)
                        state <= S_FIX;
`endif
                end
                S_DIV: begin
                    rem <= rem_next;
                    quo <= {quo[62:0], q_bit};
                    dvd <= {dvd[62:0], 1'b0};
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1)
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (dz) begin
                        resp_quo <= ext(64'hFFFF_FFFF_FFFF_FFFF,
                                        kind_q, sgn_q);
                        resp_rem <= ea;
                    end else begin
                        resp_quo <= ext(q_fix, kind_q, sgn_q);
                        resp_rem <= ext(r_fix, kind_q, sgn_q);
                    end
                    resp_dz    <= dz;
                    resp_tag   <= tag_q;
                    resp_valid <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divmod_seq.sv
// Scoreboard bench for divmod_seq: reference model built from the
// language's own / and % operators, latency and handshake checks.
module tb_divmod_seq;
    import divmod_pkg::*;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_kind = 2'd0;
    logic             req_signed = 1'b0;
    logic [63:0]      req_a = 64'd0;
    logic [63:0]      req_b = 64'd0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [63:0]      resp_quo;
    logic [63:0]      resp_rem;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_dz;

    divmod_seq #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_signed (req_signed),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_quo   (resp_quo),
        .resp_rem   (resp_rem),
        .resp_tag   (resp_tag),
        .resp_dz    (resp_dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      quo;
        logic [63:0]      rem;
        logic [TAG_W-1:0] tag;
        logic             dz;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(logic [63:0] v, int w, bit s);
        logic [63:0] m;
        if (w == 64) return v;
        m = (64'd1 << w) - 64'd1;
        v = v & m;
        if (s && v[w-1]) v = v | ~m;
        return v;
    endfunction

    function automatic exp_t model(kind_t k, bit s, logic [63:0] a,
                                   logic [63:0] b, logic [TAG_W-1:0] tag);
        exp_t        e;
        int          w;
        logic [63:0] m, ua, ub, q, r;
        longint      sa, sb_, sq, sr;
        w  = 8 << int'(k);
        m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        ua = a & m;
        ub = b & m;
        sa = longint'(ua << (64 - w));
        sa = sa >>> (64 - w);
        sb_ = longint'(ub << (64 - w));
        sb_ = sb_ >>> (64 - w);
        e.dz = (ub == 64'd0);
        if (e.dz) begin
            q = m;
            r = ua;
        end else if (s) begin
            if (sb_ == -64'sd1) begin
                sq = -sa;
                sr = 0;
            end else begin
                sq = sa / sb_;
                sr = sa % sb_;
            end
            q = sq;
            r = sr;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        e.quo = sx(q, w, s);
        e.rem = sx(r, w, s);
        e.tag = tag;
        e.lat = w + 2;
`ifdef DIVMOD_EARLY_OUT_EN
        if (ua == 64'd0 || ub == 64'd0) e.lat = 2;
`endif
        return e;
    endfunction

    task automatic send(kind_t k, bit s, logic [63:0] a, logic [63:0] b,
                        logic [TAG_W-1:0] tag);
        int n = 0;
        @(negedge clk);
        req_kind   = k;
        req_signed = s;
        req_a      = a;
        req_b      = b;
        req_tag    = tag;
        req_valid  = 1'b1;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(n < 200), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        sb.push_back(model(k, s, a, b, tag));
    endtask

    task automatic receive(int hold);
        int          n = 0;
        exp_t        e;
        logic [63:0] q0, r0;
        while (!resp_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("latency", 64'(n), 64'(e.lat));
        check("quo", resp_quo, e.quo);
        check("rem", resp_rem, e.rem);
        check("tag", 64'(resp_tag), 64'(e.tag));
        check("dz", 64'(resp_dz), 64'(e.dz));
        q0 = resp_quo;
        r0 = resp_rem;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_quo", resp_quo, q0);
            check("bp_rem", resp_rem, r0);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check("hs_valid_low", 64'(resp_valid), 64'd0);
        check("hs_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] hi;
        #12;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_quo", resp_quo, 64'd0);
        check("rst_rem", resp_rem, 64'd0);
        check("rst_tag", 64'(resp_tag), 64'd0);
        check("rst_dz", 64'(resp_dz), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(KIND_INT, 1'b1, 64'hFFFF_FFF9, 64'd2, 4'd1);
        receive(0);
        send(KIND_BYTE, 1'b1, 64'h80, 64'hFF, 4'd2);
        receive(0);
        send(KIND_BYTE, 1'b0, 64'h80, 64'hFF, 4'd3);
        receive(0);
        send(KIND_SHORTINT, 1'b0, 64'h1234, 64'd0, 4'd5);
        receive(0);
        send(KIND_LONGINT, 1'b1, 64'd100, -64'd7, 4'd6);
        receive(0);

        for (int i = 0; i < 4; i++) begin
            hi = {$urandom, $urandom};
            send(KIND_BYTE, 1'b1, {hi[63:8], 8'h9C},
                 {hi[31:0], hi[63:40], 8'h07}, 4'(i));
            receive(0);
        end

        send(KIND_INT, 1'b0, 64'd1000, 64'd7, 4'd9);
        receive(10);
        send(KIND_LONGINT, 1'b1, 64'h8000_0000_0000_0000,
             64'hFFFF_FFFF_FFFF_FFFF, 4'd10);
        receive(0);
        send(KIND_SHORTINT, 1'b1, 64'h8000, 64'hFFFF, 4'd11);
        receive(0);
        send(KIND_INT, 1'b1, 64'd0, 64'd5, 4'd12);
        receive(0);

        for (int i = 0; i < 6; i++) begin
            send(kind_t'(i % 4), 1'(i / 2), {$urandom, $urandom},
                 {$urandom, $urandom}, 4'(i + 13));
            receive(i % 3);
        end

        send(KIND_LONGINT, 1'b1, 64'd123456789, 64'd17, 4'd4);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_resp_valid", 64'(resp_valid), 64'd0);
        check("abort_req_ready", 64'(req_ready), 64'd1);
        check("abort_quo", resp_quo, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(KIND_INT, 1'b0, 64'd9, 64'd4, 4'd7);
        receive(0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
